axil_csr_slave: RTL and testbench



---
 rtl/axil_csr_slave_if.sv | 38 +++
 rtl/axil_csr_slave.sv | 197 +++++++++++++++++++
 tb/tb_axil_csr_slave.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_csr_slave_if.sv
// AXI4-Lite channel bundle between a bus master and the CSR slave.
// Parametrised on address and data width.
interface axil_csr_slave_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid,
    output b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid,
    input  ar_ready, r_data, r_resp, r_valid
  );

  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid,
    input  b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid,
    output ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axil_csr_slave.sv
// AXI4-Lite CSR register file with RO masking and access pulses.
// Define AXIL_CSR_STRB_EN to honour w_strb byte enables.
module axil_csr_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] REG_RESET = '0
) (
  input  logic aclk,
  input  logic aresetn,
  axil_csr_slave_if.slave s_axil,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0] wr_pulse,
  output logic [NUM_REGS-1:0] rd_pulse
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(SW);
  localparam int IXW = ADDR_WIDTH - OFF;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                  up;
  logic                  aw_held, w_held;
  logic [IXW-1:0]        aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
`ifdef AXIL_CSR_STRB_EN
  logic [SW-1:0]         w_strb_q;
`endif
  logic [NUM_REGS*DATA_WIDTH-1:0] reg_q;

  logic aw_fire, w_fire, ar_fire;
  logic [31:0] w_idx, ar_idx;
  logic [NUM_REGS-1:0] w_sel, r_sel;
  logic [DATA_WIDTH-1:0] r_word, w_mask;
  logic [1:0] w_resp;

  assign aw_fire = s_axil.aw_valid && s_axil.aw_ready;
  assign w_fire  = s_axil.w_valid && s_axil.w_ready;
  assign ar_fire = s_axil.ar_valid && s_axil.ar_ready;
  assign w_idx   = 32'(aw_idx_q);
  assign ar_idx  = 32'(s_axil.ar_addr[ADDR_WIDTH-1:OFF]);

  always_comb begin
    w_sel   = '0;
    r_sel   = '0;
    r_word  = '0;
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_sel[i] = (w_idx == 32'(i));
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ?
        REG_RESET[i*DATA_WIDTH +: DATA_WIDTH] :
        reg_q[i*DATA_WIDTH +: DATA_WIDTH];
      if (ar_idx == 32'(i)) begin
        r_sel[i] = 1'b1;
        r_word = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] :
                              reg_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_resp = OKAY;
    if (w_idx >= 32'(NUM_REGS))
      w_resp = DECERR;
    else if (|(w_sel & RO_MASK))
      w_resp = SLVERR;
  end

  always_comb begin
    w_mask = '1;
`ifdef AXIL_CSR_STRB_EN
    for (int b = 0; b < SW; b++)
      w_mask[b*8 +: 8] = {8{w_strb_q[b]}};
`endif
  end

  // Readies stay low until the first edge after reset release
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) up <= 1'b0;
    else          up <= 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:   if ((aw_held || aw_fire) && (w_held || w_fire))
                  w_next = W_COMMIT;
      W_COMMIT: w_next = W_RESP;
      W_RESP:   if (s_axil.b_ready) w_next = W_IDLE;
      default:  w_next = W_IDLE;
    endcase
  end

  always_comb begin
    s_axil.aw_ready = 1'b0;
    s_axil.w_ready  = 1'b0;
    s_axil.b_valid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        s_axil.aw_ready = up && !aw_held;
        s_axil.w_ready  = up && !w_held;
      end
      W_RESP:  s_axil.b_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx_q      <= '0;
      w_data_q      <= '0;
`ifdef AXIL_CSR_STRB_EN
      w_strb_q      <= '0;
`endif
      s_axil.b_resp <= OKAY;
      reg_q         <= REG_RESET;
      wr_pulse      <= '0;
    end else begin
      wr_pulse <= '0;
      if (aw_fire) begin
        aw_held  <= 1'b1;
        aw_idx_q <= s_axil.aw_addr[ADDR_WIDTH-1:OFF];
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= s_axil.w_data;
`ifdef AXIL_CSR_STRB_EN
        w_strb_q <= s_axil.w_strb;
`endif
      end
      if (w_state == W_COMMIT) begin
        aw_held       <= 1'b0;
        w_held        <= 1'b0;
        s_axil.b_resp <= w_resp;
        if (w_resp == OKAY) begin
          wr_pulse <= w_sel;
          for (int i = 0; i < NUM_REGS; i++)
            if (w_sel[i])
              reg_q[i*DATA_WIDTH +: DATA_WIDTH] <=
                (reg_q[i*DATA_WIDTH +: DATA_WIDTH] & ~w_mask) |
                (w_data_q & w_mask);
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_fire) r_next = R_RESP;
      R_RESP:  if (s_axil.r_ready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_axil.ar_ready = up && (r_state == R_IDLE);
    s_axil.r_valid  = (r_state == R_RESP);
  end

  // r_word is zero and r_sel empty for out-of-range indices
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axil.r_data <= '0;
      s_axil.r_resp <= OKAY;
      rd_pulse      <= '0;
    end else begin
      rd_pulse <= '0;
      if (ar_fire) begin
        s_axil.r_data <= r_word;
        s_axil.r_resp <= (|r_sel) ? OKAY : DECERR;
        rd_pulse      <= r_sel;
      end
    end
  end
endmodule

// File: tb/tb_axil_csr_slave.sv
// Scoreboard bench for axil_csr_slave: writes, reads, errors, resets.
// Expected B/R responses are queued at issue and popped on response.
module tb_axil_csr_slave;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h0008;

  function automatic logic [NR*DW-1:0] mk_rst();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++)
      v[i*DW +: DW] = 32'hA500_0000 | 32'(i);
    return v;
  endfunction
  localparam logic [NR*DW-1:0] RST = mk_rst();

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_csr_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  logic [NR*DW-1:0] reg_out, reg_in;
  logic [NR-1:0] wr_pulse, rd_pulse;

  axil_csr_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
    .RO_MASK(RO), .REG_RESET(RST)
  ) dut (
    .aclk(clk), .aresetn(rst_n), .s_axil(bus),
    .reg_out(reg_out), .reg_in(reg_in),
    .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  typedef struct packed {
    logic [1:0]    resp;
    logic [DW-1:0] data;
    logic [NR-1:0] pulse;
  } exp_t;

  exp_t bq[$];
  exp_t rq[$];
  logic [DW-1:0] model [NR];
  logic [NR*DW-1:0] rstv;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [NR*DW-1:0] mflat();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  task automatic model_reset();
    rstv = RST;
    for (int i = 0; i < NR; i++) model[i] = rstv[i*DW +: DW];
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [3:0] s, input int gap);
    int idx, n;
    exp_t e, g;
    logic aw_done, w_done, aw_f, w_f;
    logic [DW-1:0] m;
    idx = int'(a[AW-1:2]);
    e.data = '0;
    e.pulse = '0;
    if (idx >= NR) e.resp = 2'b11;
    else if (RO[idx]) e.resp = 2'b10;
    else begin
      e.resp = 2'b00;
      e.pulse = NR'(1) << idx;
      m = '1;
`ifdef AXIL_CSR_STRB_EN
      for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
`endif
      model[idx] = (model[idx] & ~m) | (d & m);
    end
    bq.push_back(e);
    bus.w_data = d;
    bus.w_strb = s;
    bus.w_valid = 1'b1;
    aw_done = 1'b0;
    w_done = 1'b0;
    n = 0;
    while (!(aw_done && w_done) && n < 40) begin
      if (!aw_done && n >= gap) begin
        bus.aw_addr = a;
        bus.aw_valid = 1'b1;
      end
      if (w_done && !aw_done) begin
        n_cmp++;
        if (bus.w_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL w_ready_wait: got %b need 0", bus.w_ready);
        end
      end
      aw_f = bus.aw_valid && bus.aw_ready;
      w_f = bus.w_valid && bus.w_ready;
      @(posedge clk); #1;
      if (aw_f) begin aw_done = 1'b1; bus.aw_valid = 1'b0; end
      if (w_f) begin w_done = 1'b1; bus.w_valid = 1'b0; end
      n++;
    end
    n_cmp++;
    if (!(aw_done && w_done)) begin
      n_bad++;
      $display("FAIL wr_handshake_timeout: addr %h", a);
      bus.aw_valid = 1'b0;
      bus.w_valid = 1'b0;
      void'(bq.pop_back());
      return;
    end
    n_cmp++;
    if (bus.b_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b_early: got %b need 0", bus.b_valid);
    end
    @(posedge clk); #1;
    g = bq.pop_front();
    n_cmp++;
    if (bus.b_valid !== 1'b1 || bus.b_resp !== g.resp) begin
      n_bad++;
      $display("FAIL b_resp: addr %h got v=%b r=%b need v=1 r=%b",
               a, bus.b_valid, bus.b_resp, g.resp);
    end
    n_cmp++;
    if (wr_pulse !== g.pulse) begin
      n_bad++;
      $display("FAIL wr_pulse: got %h need %h", wr_pulse, g.pulse);
    end
    n_cmp++;
    if (reg_out !== mflat()) begin
      n_bad++;
      $display("FAIL reg_out: addr %h got %h need %h", a, reg_out, mflat());
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.b_valid !== 1'b0 || wr_pulse !== '0 ||
        bus.aw_ready !== 1'b1 || bus.w_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_done: got bv=%b pulse=%h awr=%b wr=%b need 0/0/1/1",
               bus.b_valid, wr_pulse, bus.aw_ready, bus.w_ready);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, input int hold);
    int idx, n;
    exp_t e, g;
    logic fired;
    idx = int'(a[AW-1:2]);
    if (idx >= NR) begin
      e.resp = 2'b11; e.data = '0; e.pulse = '0;
    end else begin
      e.resp = 2'b00;
      e.data = RO[idx] ? reg_in[idx*DW +: DW] : model[idx];
      e.pulse = NR'(1) << idx;
    end
    rq.push_back(e);
    bus.r_ready = (hold == 0);
    bus.ar_addr = a;
    bus.ar_valid = 1'b1;
    fired = 1'b0;
    n = 0;
    while (!fired && n < 40) begin
      fired = bus.ar_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.ar_valid = 1'b0;
    n_cmp++;
    if (!fired) begin
      n_bad++;
      $display("FAIL rd_handshake_timeout: addr %h", a);
      void'(rq.pop_back());
      return;
    end
    g = rq.pop_front();
    n_cmp++;
    if (bus.r_valid !== 1'b1 || bus.r_data !== g.data ||
        bus.r_resp !== g.resp) begin
      n_bad++;
      $display("FAIL r_beat: addr %h got v=%b d=%h r=%b need v=1 d=%h r=%b",
               a, bus.r_valid, bus.r_data, bus.r_resp, g.data, g.resp);
    end
    n_cmp++;
    if (rd_pulse !== g.pulse) begin
      n_bad++;
      $display("FAIL rd_pulse: got %h need %h", rd_pulse, g.pulse);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.r_valid !== 1'b1 || bus.r_data !== g.data ||
          rd_pulse !== '0) begin
        n_bad++;
        $display("FAIL r_hold: cyc %0d got v=%b d=%h p=%h need 1/%h/0",
                 k, bus.r_valid, bus.r_data, rd_pulse, g.data);
      end
    end
    bus.r_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.r_valid !== 1'b0 || bus.ar_ready !== 1'b1 || rd_pulse !== '0) begin
      n_bad++;
      $display("FAIL rd_done: got rv=%b arr=%b p=%h need 0/1/0",
               bus.r_valid, bus.ar_ready, rd_pulse);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.aw_addr = '0; bus.aw_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_valid = 1'b0;
    bus.b_ready = 1'b0; bus.ar_addr = '0; bus.ar_valid = 1'b0;
    bus.r_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.aw_ready, bus.w_ready, bus.ar_ready,
         bus.b_valid, bus.r_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_hs: got %b need 00000", {bus.aw_ready, bus.w_ready,
               bus.ar_ready, bus.b_valid, bus.r_valid});
    end
    n_cmp++;
    if (bus.b_resp !== 2'b0 || bus.r_resp !== 2'b0 || bus.r_data !== '0) begin
      n_bad++;
      $display("FAIL rst_resp: got %b %b %h need 0", bus.b_resp, bus.r_resp,
               bus.r_data);
    end
    n_cmp++;
    if (reg_out !== mflat() || wr_pulse !== '0 || rd_pulse !== '0) begin
      n_bad++;
      $display("FAIL rst_regs: got %h need %h", reg_out, mflat());
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.ar_ready !== 1'b0 || bus.aw_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ready_early: got %b%b need 00", bus.ar_ready,
               bus.aw_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.aw_ready, bus.w_ready, bus.ar_ready} !== 3'b111) begin
      n_bad++;
      $display("FAIL rst_ready_rise: got %b need 111",
               {bus.aw_ready, bus.w_ready, bus.ar_ready});
    end
  endtask

  task automatic test_basic_write();
    bus.b_ready = 1'b1;
    wr(12'h004, 32'hDEAD_BEEF, 4'hF, 0);
    rd(12'h004, 0);
    rd(12'h006, 0);
  endtask

  task automatic test_w_before_aw();
    wr(12'h008, 32'h1234_5678, 4'hF, 2);
    rd(12'h008, 0);
  endtask

  task automatic test_strobe();
    logic [DW-1:0] want;
`ifdef AXIL_CSR_STRB_EN
    want = 32'h11BB_33DD;
`else
    want = 32'hAABB_CCDD;
`endif
    wr(12'h008, 32'h1122_3344, 4'hF, 0);
    wr(12'h008, 32'hAABB_CCDD, 4'b0101, 0);
    n_cmp++;
    if (reg_out[2*DW +: DW] !== want) begin
      n_bad++;
      $display("FAIL strobe_merge: got %h need %h", reg_out[2*DW +: DW], want);
    end
    wr(12'h010, 32'h0BAD_F00D, 4'b0000, 0);
    rd(12'h010, 0);
  endtask

  task automatic test_decerr();
    wr(12'h040, 32'hFFFF_FFFF, 4'hF, 0);
    rd(12'h040, 0);
    wr(12'hFFC, 32'h1357_9BDF, 4'hF, 1);
  endtask

  task automatic test_read_only();
    reg_in[3*DW +: DW] = 32'h5A5A_5A5A;
    wr(12'h00C, 32'hFFFF_0000, 4'hF, 0);
    rd(12'h00C, 5);
  endtask

  task automatic test_same_edge();
    exp_t e, g;
    wr(12'h01C, 32'h0000_7777, 4'hF, 0);
    e.resp = 2'b00;
    e.data = 32'h0000_7777;
    e.pulse = NR'(1) << 7;
    rq.push_back(e);
    model[7] = 32'h8888_0000;
    bus.r_ready = 1'b0;
    bus.aw_addr = 12'h01C; bus.aw_valid = 1'b1;
    bus.w_data = 32'h8888_0000; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    @(posedge clk); #1;
    bus.aw_valid = 1'b0;
    bus.w_valid = 1'b0;
    bus.ar_addr = 12'h01C;
    bus.ar_valid = 1'b1;
    @(posedge clk); #1;
    bus.ar_valid = 1'b0;
    g = rq.pop_front();
    n_cmp++;
    if (bus.r_valid !== 1'b1 || bus.r_data !== g.data) begin
      n_bad++;
      $display("FAIL same_edge_rd: got v=%b d=%h need 1/%h",
               bus.r_valid, bus.r_data, g.data);
    end
    n_cmp++;
    if (reg_out !== mflat() || bus.b_valid !== 1'b1 ||
        wr_pulse !== (NR'(1) << 7) || rd_pulse !== g.pulse) begin
      n_bad++;
      $display("FAIL same_edge_wr: got bv=%b wp=%h rp=%h r7=%h need 1/%h/%h/%h",
               bus.b_valid, wr_pulse, rd_pulse, reg_out[7*DW +: DW],
               NR'(1) << 7, g.pulse, model[7]);
    end
    bus.r_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.b_valid !== 1'b0 || bus.r_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL same_edge_done: got bv=%b rv=%b need 0/0",
               bus.b_valid, bus.r_valid);
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    logic [AW-1:0] a;
    for (int k = 0; k < 12; k++) begin
      idx = $urandom_range(0, 17);
      a = AW'(idx * 4 + int'($urandom_range(0, 3)));
      wr(a, $urandom, 4'($urandom), k % 3);
      idx = $urandom_range(0, 17);
      rd(AW'(idx * 4), k % 2);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    bus.b_ready = 1'b0;
    bus.aw_addr = 12'h018; bus.aw_valid = 1'b1;
    bus.w_data = 32'hCAFE_0006; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    @(posedge clk); #1;
    bus.aw_valid = 1'b0;
    bus.w_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.b_valid !== 1'b1 || reg_out[6*DW +: DW] !== 32'hCAFE_0006) begin
      n_bad++;
      $display("FAIL mid_pre: got bv=%b r6=%h need 1/cafe0006",
               bus.b_valid, reg_out[6*DW +: DW]);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    bq.delete();
    n_cmp++;
    if (bus.b_valid !== 1'b0 || reg_out !== mflat()) begin
      n_bad++;
      $display("FAIL mid_rst: got bv=%b regs=%h need 0/%h", bus.b_valid,
               reg_out, mflat());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.b_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.b_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_no_b: got b_valid after reset, need none");
    end
    rd(12'h018, 0);
  endtask

  initial begin
    reg_in = '0;
    for (int i = 0; i < NR; i++) reg_in[i*DW +: DW] = 32'h0F0F_0000 | 32'(i);
    test_reset();
    test_basic_write();
    test_w_before_aw();
    test_strobe();
    test_decerr();
    test_read_only();
    test_same_edge();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
